// File: rtl/slow_mem_responder_if.sv
// rtl/slow_mem_responder_if.sv - 128-bit cache-line bus between a cache and its backing memory
// master: mem_read, mem_write, mem_addr (line address, byte bits [31:4]), mem_wdata
// slave : mem_rdata (read line), mem_ready (one-cycle completion pulse)
interface slow_mem_responder_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/slow_mem_responder.sv
// rtl/slow_mem_responder.sv - fixed-latency line-sized memory responder with error flag and counter
// clk       : system clock, rising edge
// rst_n     : asynchronous active-low reset (storage array is not cleared)
// bus       : slave side of the line bus (read/write request, address, data, ready pulse)
// proto_err : sticky flag, set on simultaneous read+write or a request dropped before completion
// xact_cnt  : completed-transaction count, saturating at 16'hFFFF
module slow_mem_responder #(
    parameter int LAT   = 8,
    parameter int IDX_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    slow_mem_responder_if.slave bus,
    output logic                proto_err,
    output logic [15:0]         xact_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LAT - 1);
    localparam int         DEPTH    = 1 << IDX_W;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic [IDX_W-1:0]   idx_q;
    logic [127:0]       wdata_q;
    logic [127:0]       rdata_q;
    logic               op_rd_q;
    logic               perr_q;
    logic [15:0]        xcnt_q;

    logic [127:0]       mem_q [0:DEPTH-1];

    logic               req;
    logic               held;
    logic               accept;
    logic               abort;
    logic               load_rdata;
    logic               complete;
    logic [IDX_W-1:0]   in_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign req    = bus.mem_read | bus.mem_write;
    // Only the signal that opened the transaction must stay high; a
    // simultaneous request is tracked as a read.
    assign held   = op_rd_q ? bus.mem_read : bus.mem_write;
    assign in_idx = bus.mem_addr[IDX_W-1:0];
    // With LAT=1 the line is fetched on the acceptance edge itself, before
    // idx_q holds the captured index.
    assign rd_idx = (state_q == IDLE) ? in_idx : idx_q;

    generate
        if (IDX_W < 28) begin : g_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.mem_addr[27:IDX_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        abort      = 1'b0;
        load_rdata = 1'b0;
        complete   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    cnt_d  = CNT_LOAD;
                    if (LAT == 1) begin
                        state_d    = RESP;
                        load_rdata = bus.mem_read;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (!held) begin
                    abort   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (cnt_q == 8'd1) begin
                    // Counter reaches zero on this edge: LAT-1 busy cycles
                    // plus the response cycle make up the full latency.
                    state_d    = RESP;
                    load_rdata = op_rd_q;
                end
            end
            RESP: begin
                complete = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_rd_q <= 1'b0;
            rdata_q <= '0;
            perr_q  <= 1'b0;
            xcnt_q  <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                idx_q   <= in_idx;
                wdata_q <= bus.mem_wdata;
                op_rd_q <= bus.mem_read;
                if (bus.mem_read && bus.mem_write) begin
                    perr_q <= 1'b1;
                end
            end
            if (abort) begin
                perr_q <= 1'b1;
            end
            if (load_rdata) begin
                rdata_q <= mem_q[rd_idx];
            end
            if (complete && (xcnt_q != 16'hFFFF)) begin
                xcnt_q <= xcnt_q + 16'd1;
            end
        end
    end

    // Line storage survives reset; an async reset forces state_q to IDLE,
    // so an interrupted write can never reach this commit.
    always_ff @(posedge clk) begin
        if ((state_q == RESP) && !op_rd_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.mem_ready = (state_q == RESP);
    assign bus.mem_rdata = rdata_q;
    assign proto_err     = perr_q;
    assign xact_cnt      = xcnt_q;

endmodule
